// File: rtl/mem_port_arbiter.sv
// Two-way round-robin arbiter that owns the single memory port, sequencing
// each access over MEM_LAT strobe cycles followed by a one-cycle acknowledge.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              pnl_req,
  input  logic              pnl_we,
  input  logic [ADDR_W-1:0] pnl_addr,
  input  logic [DATA_W-1:0] pnl_wdata,
  output logic              pnl_ack,
  input  logic              pnl_en,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              pnl_ack_q, pnl_ack_d;

  logic              pnl_elig;
  logic              grant_pnl;
  logic              grant_we;

  assign pnl_elig = pnl_req & pnl_en;

  // rr_q = 1 means the panel wins the next tie, i.e. the CPU owned the last grant.
  assign grant_pnl = pnl_elig & (~cpu_req | rr_q);
  assign grant_we  = grant_pnl ? pnl_we : cpu_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    cpu_ack_d   = 1'b0;
    pnl_ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || pnl_elig) begin
          owner_d     = grant_pnl;
          rr_d        = ~grant_pnl;
          mem_addr_d  = grant_pnl ? pnl_addr : cpu_addr;
          mem_wdata_d = grant_pnl ? pnl_wdata : cpu_wdata;
          mem_read_d  = ~grant_we;
          mem_write_d = grant_we;
          cnt_d       = LAT_M1;
          busy_d      = 1'b1;
          state_d     = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (mem_read_q) begin
            rdata_d = mem_rdata;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          cpu_ack_d   = ~owner_q;
          pnl_ack_d   = owner_q;
          state_d     = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACK: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      cpu_ack_q   <= 1'b0;
      pnl_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      pnl_ack_q   <= pnl_ack_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign pnl_ack   = pnl_ack_q;
  assign rdata     = rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at MEM_LAT=3, a second
// instance at MEM_LAT=1 sharing the stimulus for the asynchronous reset check.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          pnl_req = 1'b0, pnl_we = 1'b0, pnl_en = 1'b0;
  logic [AW-1:0] pnl_addr = '0;
  logic [DW-1:0] pnl_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;

  logic          cpu_ack, pnl_ack, mem_read, mem_write, owner, busy;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          l1_cpu_ack, l1_pnl_ack, l1_mem_read, l1_mem_write, l1_owner, l1_busy;
  logic [DW-1:0] l1_rdata, l1_mem_wdata;
  logic [AW-1:0] l1_mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
    .pnl_ack(pnl_ack), .pnl_en(pnl_en),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(l1_cpu_ack),
    .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
    .pnl_ack(l1_pnl_ack), .pnl_en(pnl_en),
    .rdata(l1_rdata), .mem_read(l1_mem_read), .mem_write(l1_mem_write),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata),
    .owner(l1_owner), .busy(l1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the strobe invariants there.
  task automatic step();
    logic viol;
    @(negedge clk);
    viol = (mem_read & mem_write)
         | ((cpu_ack | pnl_ack) & (mem_read | mem_write))
         | (~busy & (mem_read | mem_write));
    chk("strobe_invariant", 32'(viol), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   grants;
    int   acks;
    logic prev_busy;

    // ---------------- reset state ----------------
    repeat (2) step();
    chk("rst_ctl",  32'({cpu_ack, pnl_ack, owner, busy, mem_read, mem_write}), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_data", 32'({mem_wdata, rdata}), 32'h0);

    // ---------------- async reset mid-access ----------------
    rst       = 1'b1;
    cpu_req   = 1'b1;
    cpu_addr  = 16'h0077;
    mem_rdata = 8'h11;
    step();
    chk("l1_pre_rst_read", 32'(l1_mem_read), 32'h1);
    chk("pre_rst_read",    32'(mem_read), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("l1_async_ctl",  32'({l1_cpu_ack, l1_pnl_ack, l1_owner, l1_busy, l1_mem_read, l1_mem_write}), 32'h0);
    chk("l1_async_addr", 32'(l1_mem_addr), 32'h0);
    chk("async_ctl",     32'({cpu_ack, pnl_ack, owner, busy, mem_read, mem_write}), 32'h0);
    pnl_req   = 1'b1;
    pnl_en    = 1'b1;
    pnl_we    = 1'b1;
    pnl_addr  = 16'h0099;
    #1 rst = 1'b1;
    step();
    chk("l1_first_tie_owner", 32'(l1_owner), 32'h0);
    chk("l1_first_tie_read",  32'(l1_mem_read), 32'h1);
    chk("l1_first_tie_addr",  32'(l1_mem_addr), 32'h0077);
    chk("first_tie_owner",    32'(owner), 32'h0);
    chk("first_tie_read",     32'(mem_read), 32'h1);
    cpu_req = 1'b0;
    pnl_req = 1'b0;
    pnl_en  = 1'b0;
    rst     = 1'b0;
    step();
    rst     = 1'b1;

    // ---------------- CPU read, MEM_LAT=3 ----------------
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0012;
    mem_rdata = 8'hA5;
    step();
    chk("rd_c0_read", 32'(mem_read), 32'h1);
    chk("rd_c0_addr", 32'(mem_addr), 32'h0012);
    chk("rd_c0_busy", 32'(busy), 32'h1);
    chk("rd_c0_ack",  32'(cpu_ack), 32'h0);
    step();
    chk("rd_c1_read", 32'(mem_read), 32'h1);
    step();
    chk("rd_c2_read", 32'(mem_read), 32'h1);
    chk("rd_c2_addr", 32'(mem_addr), 32'h0012);
    step();
    chk("rd_c3_read",  32'(mem_read), 32'h0);
    chk("rd_c3_ack",   32'(cpu_ack), 32'h1);
    chk("rd_c3_pack",  32'(pnl_ack), 32'h0);
    chk("rd_c3_rdata", 32'(rdata), 32'hA5);
    chk("rd_c3_busy",  32'(busy), 32'h1);
    mem_rdata = 8'h5A;
    step();
    chk("rd_c4_ack",  32'(cpu_ack), 32'h0);
    chk("rd_c4_busy", 32'(busy), 32'h0);
    step();
    chk("rd_c5_regrant", 32'(mem_read), 32'h1);
    chk("rd_c5_owner",   32'(owner), 32'h0);
    cpu_req = 1'b0;
    step();
    step();
    step();
    chk("rd2_ack",   32'(cpu_ack), 32'h1);
    chk("rd2_rdata", 32'(rdata), 32'h5A);
    step();
    chk("rd2_idle", 32'(busy), 32'h0);

    // ---------------- panel write gated by pnl_en ----------------
    pnl_req   = 1'b1;
    pnl_we    = 1'b1;
    pnl_addr  = 16'h0040;
    pnl_wdata = 8'h3C;
    pnl_en    = 1'b0;
    mem_rdata = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("gate_c%0d_strobes", i), 32'({mem_read, mem_write, busy}), 32'h0);
    end
    pnl_en = 1'b1;
    step();
    chk("wr_c0_write", 32'({mem_read, mem_write}), 32'h1);
    chk("wr_c0_addr",  32'(mem_addr), 32'h0040);
    chk("wr_c0_wdata", 32'(mem_wdata), 32'h3C);
    chk("wr_c0_owner", 32'(owner), 32'h1);
    step();
    step();
    chk("wr_c2_write", 32'(mem_write), 32'h1);
    step();
    chk("wr_c3_acks",  32'({cpu_ack, pnl_ack}), 32'h1);
    chk("wr_c3_write", 32'(mem_write), 32'h0);
    chk("wr_c3_rdata", 32'(rdata), 32'h5A);
    pnl_req = 1'b0;
    step();
    chk("wr_c4_ack", 32'(pnl_ack), 32'h0);

    // ---------------- round-robin under contention ----------------
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0001;
    pnl_req  = 1'b1;
    pnl_we   = 1'b1;
    pnl_addr = 16'h0002;
    grants    = 0;
    prev_busy = busy;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      step();
      if (busy && !prev_busy) begin
        chk($sformatf("rr_owner%0d", grants), 32'(owner), 32'(grants % 2));
        chk($sformatf("rr_addr%0d", grants), 32'(mem_addr), (grants % 2 == 1) ? 32'h2 : 32'h1);
      end
      if (busy && !prev_busy) grants++;
      prev_busy = busy;
    end
    chk("rr_grants", 32'(grants), 32'h4);
    cpu_req = 1'b0;
    pnl_req = 1'b0;
    for (int cyc = 0; cyc < 20 && busy; cyc++) step();
    chk("rr_drain_busy", 32'(busy), 32'h0);

    // ---------------- mid-access disturbance ----------------
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0100;
    step();
    chk("dist_grant_addr",  32'(mem_addr), 32'h0100);
    chk("dist_grant_owner", 32'(owner), 32'h0);
    chk("dist_grant_read",  32'(mem_read), 32'h1);
    cpu_addr = 16'h0200;
    cpu_req  = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) chk("dist_hold_addr", 32'(mem_addr), 32'h0100);
      acks += int'(cpu_ack);
    end
    chk("dist_ack_count", 32'(acks), 32'h1);
    chk("dist_final_addr", 32'(mem_addr), 32'h0100);
    chk("dist_final_idle", 32'({busy, mem_read, mem_write}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: the CPU dataflow and the front-panel loader (switch-driven program entry and inspection).
- Sits between the requesters and the memory block, and owns the memory read, write, address and write-data strobes.
- Sequences each access over a fixed memory latency and returns a one-cycle acknowledge to the owning requester.
- Uses round-robin arbitration. Panel access is gated by a panel-enable input that is driven from the CPU halted state.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- MEM_LAT, 1, number of cycles the strobes are held per access; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- pnl_req  in  1  panel access request; level.
- pnl_we  in  1  panel write select.
- pnl_addr  in  ADDR_W  panel address.
- pnl_wdata  in  DATA_W  panel write data (switches D).
- pnl_ack  out  1  one-cycle completion pulse to the panel.
- pnl_en  in  1  1 = panel requests eligible; 0 = panel requests ignored.
- rdata  out  DATA_W  registered read data, valid while either ack is high.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data.
- owner  out  1  0 = CPU, 1 = panel; the current or last grant.
- busy  out  1  high in the ACCESS and ACK states.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: acks, strobes, mem_addr, mem_wdata, rdata, busy, owner.
  - The round-robin pointer is set to favour the CPU.
  - The latency counter is cleared.
  - An access in progress is abandoned and no ack is issued.
- States are IDLE, ACCESS and ACK.
- IDLE:
  - Eligible requests are cpu_req, and pnl_req only when pnl_en=1.
  - If none are eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the requester that did not own the previous grant. After reset, the CPU wins the first tie.
  - On the grant edge:
    - register the winner's addr, wdata and we into mem_addr and mem_wdata;
    - set owner;
    - assert mem_read = !we or mem_write = we;
    - load the counter with MEM_LAT-1;
    - go to ACCESS.
- ACCESS:
  - The strobe, address and data are held stable for exactly MEM_LAT cycles.
  - On the edge where the counter is 0:
    - capture mem_rdata into rdata (reads only; on writes rdata is unchanged);
    - deassert both strobes;
    - pulse the owner's ack;
    - go to ACK.
  - Otherwise, decrement the counter.
- ACK:
  - The ack is high for exactly one cycle and rdata is valid during it.
  - The next edge clears the ack and returns to IDLE.
  - Requests are not sampled in ACK. A request still high is resampled in IDLE.
- Timing:
  - Request sampled at edge N gives strobes high during cycles N..N+MEM_LAT-1.
  - The ack is high during cycle N+MEM_LAT.
  - The next grant is possible at edge N+MEM_LAT+2.
  - Minimum access period is MEM_LAT+2 cycles.
- Request dropped mid-access: the access still completes and the ack still pulses. The requester must ignore it.
- pnl_en falling mid-access: the panel access still completes. Only new grants are blocked.
- Address and data changes by a requester after the grant have no effect on the current access.
- mem_read and mem_write are never high together. Strobes are never high in IDLE or ACK.
- No arithmetic other than the counter. The counter width is 4 bits and it does not wrap.

Test Plan:
- Reset check, MEM_LAT=1: drive rst=0 while in ACCESS with mem_read=1 → all outputs 0 immediately, with no clock edge needed. Release reset with cpu_req and pnl_req both high and pnl_en=1 → the CPU is granted first and owner=0.
- CPU read, MEM_LAT=3: cpu_addr=16'h0012, mem_rdata=8'hA5, request sampled at edge 0 → mem_read high for 3 cycles with mem_addr=0012, cpu_ack high for one cycle, rdata=A5, and the next grant is possible at edge 5.
- Panel write with pnl_en gating: pnl_req=1 with pnl_en=0 for 10 cycles → no strobe. Set pnl_en=1, pnl_addr=0040, pnl_wdata=3C → one mem_write with mem_addr=0040 and mem_wdata=3C, then pnl_ack; rdata is unchanged.
- Round-robin: hold cpu_req=1 and pnl_req=1 with pnl_en=1 → grants alternate CPU, panel, CPU, panel, and no requester receives two consecutive grants.
- Mid-access disturbance: after the CPU grant, change cpu_addr and drop cpu_req → mem_addr stays at the original value and cpu_ack still pulses once. Check that mem_read and mem_write are never both 1 and that neither is high in IDLE or ACK.
